// File: rtl/ccc_cfg_sequencer.sv
// Reconfigures CCC output path B or C: bypass, load div/mux codes, wait for stable lock, release.
// Define CCC_SEQ_TIMEOUT_EN to add the LOCK_TIMEOUT abort that reverts the path's previous codes.
module ccc_cfg_sequencer #(
  parameter int unsigned GUARD_CYC    = 4,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       cfg_req,
  input  logic       cfg_sel,
  input  logic [4:0] cfg_div,
  input  logic [2:0] cfg_mux,
  input  logic       LOCK,
  output logic       busy,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic [4:0] OBDIV,
  output logic [4:0] OCDIV,
  output logic [2:0] OBMUX,
  output logic [2:0] OCMUX,
  output logic       BYPASSB,
  output logic       BYPASSC
);

  localparam int unsigned DIV_W  = 5;
  localparam int unsigned MUX_W  = 3;
  localparam int unsigned GCNT_W = $clog2(GUARD_CYC + 1);
  localparam int unsigned SCNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_RST = 5'b00011;
  localparam logic [MUX_W-1:0] MUX_RSV = 3'd5;

  generate
    if (GUARD_CYC < 1 || SETTLE_CYC < 1 || LOCK_TIMEOUT < 2) begin : g_bad_param
      $error("ccc_cfg_sequencer: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_BYPASS, S_APPLY, S_WAIT_LOCK, S_RELEASE, S_DONE, S_ERR
  } state_t;

  state_t             r_state, w_state;
  logic [GCNT_W-1:0]  r_gcnt, w_gcnt;
  logic [SCNT_W-1:0]  r_settle, w_settle, w_settle_inc;
  logic               r_err_flag, w_err_flag;
  logic               r_sel, w_sel;
  logic [DIV_W-1:0]   r_div, w_div;
  logic [MUX_W-1:0]   r_mux, w_mux;
  logic [DIV_W-1:0]   r_obdiv, w_obdiv, r_ocdiv, w_ocdiv;
  logic [MUX_W-1:0]   r_obmux, w_obmux, r_ocmux, w_ocmux;
  logic               r_bypassb, w_bypassb, r_bypassc, w_bypassc;
  logic               r_busy, w_busy, r_ack, w_ack, r_err, w_err;
  logic               r_lock_meta, r_lock_s;
  logic               w_settle_done;
`ifdef CCC_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TMO_W-1:0]   r_tmo, w_tmo, w_tmo_inc;
  logic [DIV_W-1:0]   r_rev_div, w_rev_div;
  logic [MUX_W-1:0]   r_rev_mux, w_rev_mux;
  logic               w_tmo_done;
`endif

  // LOCK is asynchronous to PCLK; only r_lock_s is used downstream
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= LOCK;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= S_IDLE;
      r_gcnt     <= '0;
      r_settle   <= '0;
      r_err_flag <= 1'b0;
      r_sel      <= 1'b0;
      r_div      <= '0;
      r_mux      <= '0;
      r_obdiv    <= DIV_RST;
      r_ocdiv    <= DIV_RST;
      r_obmux    <= '0;
      r_ocmux    <= '0;
      r_bypassb  <= 1'b1;
      r_bypassc  <= 1'b1;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
`ifdef CCC_SEQ_TIMEOUT_EN
      r_tmo      <= '0;
      r_rev_div  <= '0;
      r_rev_mux  <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_gcnt     <= w_gcnt;
      r_settle   <= w_settle;
      r_err_flag <= w_err_flag;
      r_sel      <= w_sel;
      r_div      <= w_div;
      r_mux      <= w_mux;
      r_obdiv    <= w_obdiv;
      r_ocdiv    <= w_ocdiv;
      r_obmux    <= w_obmux;
      r_ocmux    <= w_ocmux;
      r_bypassb  <= w_bypassb;
      r_bypassc  <= w_bypassc;
      r_busy     <= w_busy;
      r_ack      <= w_ack;
      r_err      <= w_err;
`ifdef CCC_SEQ_TIMEOUT_EN
      r_tmo      <= w_tmo;
      r_rev_div  <= w_rev_div;
      r_rev_mux  <= w_rev_mux;
`endif
    end
  end

  assign w_settle_inc  = r_settle + SCNT_W'(1);
  assign w_settle_done = r_lock_s && (w_settle_inc == SCNT_W'(SETTLE_CYC));
`ifdef CCC_SEQ_TIMEOUT_EN
  assign w_tmo_inc  = r_tmo + TMO_W'(1);
  assign w_tmo_done = (w_tmo_inc == TMO_W'(LOCK_TIMEOUT));
`endif

  // Outputs are registered off the next state, so they change on the transition edge
  always_comb begin
    w_state    = r_state;
    w_gcnt     = r_gcnt;
    w_settle   = r_settle;
    w_err_flag = r_err_flag;
    w_sel      = r_sel;
    w_div      = r_div;
    w_mux      = r_mux;
    w_obdiv    = r_obdiv;
    w_ocdiv    = r_ocdiv;
    w_obmux    = r_obmux;
    w_ocmux    = r_ocmux;
    w_bypassb  = r_bypassb;
    w_bypassc  = r_bypassc;
`ifdef CCC_SEQ_TIMEOUT_EN
    w_tmo      = r_tmo;
    w_rev_div  = r_rev_div;
    w_rev_mux  = r_rev_mux;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (cfg_req) begin
          if (cfg_mux >= MUX_RSV) begin
            w_state = S_ERR;
          end else begin
            w_state    = S_BYPASS;
            w_gcnt     = '0;
            w_err_flag = 1'b0;
            w_sel      = cfg_sel;
            w_div      = cfg_div;
            w_mux      = cfg_mux;
            if (cfg_sel) begin
              w_bypassc = 1'b1;
`ifdef CCC_SEQ_TIMEOUT_EN
              w_rev_div = r_ocdiv;
              w_rev_mux = r_ocmux;
`endif
            end else begin
              w_bypassb = 1'b1;
`ifdef CCC_SEQ_TIMEOUT_EN
              w_rev_div = r_obdiv;
              w_rev_mux = r_obmux;
`endif
            end
          end
        end
      end
      S_BYPASS: begin
        if (r_gcnt == GCNT_W'(GUARD_CYC - 1)) begin
          w_gcnt  = '0;
          w_state = S_APPLY;
          if (r_sel) begin
            w_ocdiv = r_div;
            w_ocmux = r_mux;
          end else begin
            w_obdiv = r_div;
            w_obmux = r_mux;
          end
        end else begin
          w_gcnt = r_gcnt + GCNT_W'(1);
        end
      end
      S_APPLY: begin
        if (r_gcnt == GCNT_W'(GUARD_CYC - 1)) begin
          w_gcnt   = '0;
          w_settle = '0;
`ifdef CCC_SEQ_TIMEOUT_EN
          w_tmo    = '0;
`endif
          w_state  = S_WAIT_LOCK;
        end else begin
          w_gcnt = r_gcnt + GCNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        w_settle = r_lock_s ? w_settle_inc : '0;
`ifdef CCC_SEQ_TIMEOUT_EN
        w_tmo    = w_tmo_inc;
`endif
        // Settle wins over timeout when both land on the same cycle
        if (w_settle_done) begin
          w_state = S_RELEASE;
          if (r_sel) w_bypassc = 1'b0;
          else       w_bypassb = 1'b0;
`ifdef CCC_SEQ_TIMEOUT_EN
        end else if (w_tmo_done) begin
          w_state    = S_RELEASE;
          w_err_flag = 1'b1;
          if (r_sel) begin
            w_ocdiv   = r_rev_div;
            w_ocmux   = r_rev_mux;
            w_bypassc = 1'b0;
          end else begin
            w_obdiv   = r_rev_div;
            w_obmux   = r_rev_mux;
            w_bypassb = 1'b0;
          end
`endif
        end
      end
      S_RELEASE: w_state = r_err_flag ? S_ERR : S_DONE;
      S_DONE:    w_state = S_IDLE;
      S_ERR:     w_state = S_IDLE;
      default:   w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
    w_ack  = (w_state == S_DONE);
    w_err  = (w_state == S_ERR);
  end

  assign busy    = r_busy;
  assign cfg_ack = r_ack;
  assign cfg_err = r_err;
  assign OBDIV   = r_obdiv;
  assign OCDIV   = r_ocdiv;
  assign OBMUX   = r_obmux;
  assign OCMUX   = r_ocmux;
  assign BYPASSB = r_bypassb;
  assign BYPASSC = r_bypassc;

endmodule
